// File: rtl/layers_sched_if.sv
// Image path between the image buffer, the scheduler and the layers datapath.
//
// Handshake: a beat moves across a link in every cycle where its valid and
// ready are both 1 on the rising clock edge. Valid does not depend on ready;
// the scheduler passes both directions through combinationally, so one
// handshake on the image side is exactly one handshake on the source side.
//
// Signals
//   src_bus    image words from the buffer (GROUP_NB words of IMG_WIDTH bits)
//   src_val    buffer beat valid
//   src_rdy    buffer beat accepted
//   image_bus  image words towards layers
//   image_last last beat of the current pass
//   image_val  beat valid towards layers
//   image_rdy  layers ready
//
// Modports
//   master  scheduler side
//   slave   buffer/layers side (environment)
interface layers_sched_if #(
    parameter int GROUP_NB  = 4,
    parameter int IMG_WIDTH = 16
);
    logic [GROUP_NB*IMG_WIDTH-1:0] src_bus;
    logic                          src_val;
    logic                          src_rdy;
    logic [GROUP_NB*IMG_WIDTH-1:0] image_bus;
    logic                          image_last;
    logic                          image_val;
    logic                          image_rdy;

    modport master (
        input  src_bus, src_val, image_rdy,
        output src_rdy, image_bus, image_last, image_val
    );

    modport slave (
        output src_bus, src_val, image_rdy,
        input  src_rdy, image_bus, image_last, image_val
    );
endinterface

// File: rtl/layers_sched.sv
// Run-level scheduler in front of the layers datapath.
// Gates the image stream into layers, marks the last beat of every pass,
// drives the kernel/bias buffer read address, and tracks passes issued and
// results returned to report busy/done for one convolution run.
//
// Optional feature macro: SCHED_TIMEOUT_EN
//   defined   - DRAIN watchdog; expiry ends the run with error=1
//   undefined - no watchdog, error is tied to 0, DRAIN waits for results
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cfg_data/addr/valid   config bus into the shadow registers
//   start                 begin a run (pulse, ignored while busy)
//   busy, done, error     run status; done is a one-cycle pulse
//   strm                  image path (layers_sched_if master)
//   ker_addr              kernel/bias buffer read address
//   result_val/rdy        monitored result handshake from layers
//   dbg_state             current FSM state (one-hot)
module layers_sched #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int KER_AWIDTH = 10,
    parameter int CNT_WIDTH  = 16,
    parameter int TO_WIDTH   = 12,
    parameter logic [CFG_AWIDTH-1:0] CFG_SCHED_BEATS  = 'd0,
    parameter logic [CFG_AWIDTH-1:0] CFG_SCHED_PASSES = 'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_DWIDTH-1:0] cfg_data,
    input  logic [CFG_AWIDTH-1:0] cfg_addr,
    input  logic                  cfg_valid,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    layers_sched_if.master        strm,
    output logic [KER_AWIDTH-1:0] ker_addr,
    input  logic                  result_val,
    input  logic                  result_rdy,
    output logic [3:0]            dbg_state
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        RUN   = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    // Shadow config (written any time) and active config (frozen per run).
    logic [CNT_WIDTH-1:0] sh_beat_nb, sh_res_nb, sh_pass_nb;
    logic [CNT_WIDTH-1:0] beat_nb, res_nb, pass_nb;

    logic [CNT_WIDTH-1:0] beat_cnt, pass_cnt, res_cnt, res_cnt_nxt;
    logic [CNT_WIDTH-1:0] beat_last_idx;

    logic run, launch, beat_acc, is_last, pass_end, res_hs, res_met, wd_expire;

    assign run    = (state_q == RUN);
    assign busy   = (state_q == RUN) || (state_q == DRAIN);
    assign done   = (state_q == DONE);
    assign launch = (state_q == IDLE) && start;

    assign dbg_state = state_q;

    // Zero-latency pass-through, only open while a run is issuing beats.
    assign strm.image_bus = strm.src_bus;
    assign strm.image_val = strm.src_val & run;
    assign strm.src_rdy   = strm.image_rdy & run;

    assign beat_acc = strm.image_val & strm.image_rdy;

    // beat_nb==0 behaves like 1, so every beat closes a pass.
    assign beat_last_idx   = (beat_nb == '0) ? '0 : beat_nb - CNT_ONE;
    assign is_last         = (beat_cnt == beat_last_idx);
    assign strm.image_last = run & is_last;
    assign ker_addr        = beat_cnt[KER_AWIDTH-1:0];

    assign pass_end = beat_acc & is_last & (pass_cnt == pass_nb - CNT_ONE);

    // Results are counted in every busy state, including the RUN->DRAIN cycle.
    // Looking at the count including this cycle's handshake lets done follow
    // the final result by one cycle.
    assign res_hs      = result_val & result_rdy & busy;
    assign res_cnt_nxt = res_hs ? res_cnt + CNT_ONE : res_cnt;
    assign res_met     = (res_cnt_nxt >= res_nb);

`ifdef SCHED_TIMEOUT_EN
    localparam logic [TO_WIDTH-1:0] WD_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

    logic [TO_WIDTH-1:0] wd_cnt;
    logic                error_q;

    // Expires on the DRAIN cycle that would bring the count to all-ones.
    assign wd_expire = (state_q == DRAIN) && !res_hs && !res_met && (wd_cnt == WD_LAST);
    assign error     = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            error_q <= 1'b0;
        end else if (launch) begin
            wd_cnt  <= '0;
            error_q <= 1'b0;
        end else if (state_q == DRAIN) begin
            wd_cnt <= res_hs ? '0 : wd_cnt + 1'b1;
            if (wd_expire) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (sh_pass_nb == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pass_end) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (res_met || wd_expire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Config shadow registers: a write never disturbs an in-flight run.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_beat_nb <= '0;
            sh_res_nb  <= '0;
            sh_pass_nb <= '0;
        end else if (cfg_valid) begin
            if (cfg_addr == CFG_SCHED_BEATS) begin
                sh_beat_nb <= cfg_data[CNT_WIDTH-1:0];
                sh_res_nb  <= cfg_data[16 +: CNT_WIDTH];
            end
            if (cfg_addr == CFG_SCHED_PASSES) begin
                sh_pass_nb <= cfg_data[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_nb  <= '0;
            res_nb   <= '0;
            pass_nb  <= '0;
            beat_cnt <= '0;
            pass_cnt <= '0;
            res_cnt  <= '0;
        end else if (launch) begin
            beat_nb  <= sh_beat_nb;
            res_nb   <= sh_res_nb;
            pass_nb  <= sh_pass_nb;
            beat_cnt <= '0;
            pass_cnt <= '0;
            res_cnt  <= '0;
        end else begin
            if (beat_acc) begin
                if (is_last) begin
                    beat_cnt <= '0;
                    pass_cnt <= pass_cnt + CNT_ONE;
                end else begin
                    beat_cnt <= beat_cnt + CNT_ONE;
                end
            end
            res_cnt <= res_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_layers_sched.sv
// Self-checking bench for layers_sched.
// Expected image beats {last, ker_addr, data} and expected done pulses
// (carrying the expected error flag) are queued when a run is set up; monitor
// processes pop and compare whenever the DUT hands a beat to layers or pulses
// done.
module tb_layers_sched;

`ifdef SCHED_TIMEOUT_EN
    localparam int TB_TO_WIDTH = 4;
`else
    localparam int TB_TO_WIDTH = 12;
`endif
    localparam int DW = 64;
    localparam int EW = 1 + 10 + DW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_data = '0;
    logic [4:0]  cfg_addr = '0;
    logic        cfg_valid = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [9:0]  ker_addr;
    logic        result_val = 1'b0;
    logic        result_rdy = 1'b0;
    logic [3:0]  dbg_state;

    layers_sched_if #(.GROUP_NB(4), .IMG_WIDTH(16)) strm ();

    layers_sched #(.TO_WIDTH(TB_TO_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .strm       (strm),
        .ker_addr   (ker_addr),
        .result_val (result_val),
        .result_rdy (result_rdy),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int drv_data = 0;
    int exp_data = 0;
    int done_seen = 0;
    int done_goal = 0;
    logic done_prev = 1'b0;

    logic [EW-1:0] exp_q[$];
    logic [0:0]    done_q[$];

    function automatic logic [DW-1:0] mk(int d);
        logic [15:0] w;
        w = d[15:0];
        return {w + 16'h3000, w + 16'h2000, w + 16'h1000, w};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard push helpers
    task automatic push_run(int n, int bn);
        for (int k = 0; k < n; k++) begin
            logic        l;
            logic [9:0]  ka;
            l  = ((k % bn) == bn - 1);
            ka = 10'(k % bn);
            exp_q.push_back({l, ka, mk(exp_data)});
            exp_data++;
        end
    endtask

    task automatic push_done(logic err);
        done_q.push_back(err);
        done_goal++;
    endtask

    // monitors
    always @(negedge clk) begin
        if (!rst && strm.image_val && strm.image_rdy) begin
            logic [EW-1:0] e;
            logic [EW-1:0] a;
            a = {strm.image_last, ker_addr, strm.image_bus};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat actual=%0h required=none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL beat actual last=%0b ker=%0d data=%0h required last=%0b ker=%0d data=%0h",
                             a[EW-1], a[EW-2 -: 10], a[DW-1:0], e[EW-1], e[EW-2 -: 10], e[DW-1:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            checks++;
            if (done_prev) begin
                errors++;
                $display("FAIL done_width actual=2+cycles required=1");
            end else if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                logic [0:0] e;
                e = done_q.pop_front();
                if (error !== e) begin
                    errors++;
                    $display("FAIL done_error actual=%0b required=%0b", error, e);
                end
            end
            done_seen++;
        end
        done_prev = (done === 1'b1);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(logic [4:0] a, logic [31:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_beats(int n, bit toggle);
        int acc;
        int cyc;
        bit hs;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 200) begin
            strm.image_rdy = toggle ? ~cyc[0] : 1'b1;
            @(negedge clk);
            hs = strm.image_val && strm.image_rdy;
            check("src_rdy_mirror", {63'd0, strm.src_rdy}, {63'd0, strm.image_rdy});
            tick();
            if (hs) begin
                acc++;
                drv_data++;
                strm.src_bus = mk(drv_data);
            end
            cyc++;
        end
        strm.image_rdy = 1'b0;
        if (acc < n) begin
            errors++;
            $display("FAIL beat_timeout actual=%0d required=%0d", acc, n);
        end
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (done_seen < done_goal && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("done_reached", done_seen, done_goal);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        strm.src_bus   = mk(0);
        strm.src_val   = 1'b0;
        strm.image_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_ker_addr", ker_addr, 0);
        check("rst_src_rdy", strm.src_rdy, 0);
        check("rst_image_val", strm.image_val, 0);

        // 1: beat_nb=4, pass_nb=2, res_nb=1
        cfg_write(5'd0, 32'h0001_0004);
        cfg_write(5'd1, 32'd2);
        push_run(8, 4);
        push_done(1'b0);
        strm.src_val = 1'b1;
        pulse_start();
        check("t1_busy", busy, 1);
        drive_beats(8, 1'b0);
        check("t1_drain_wait", busy, 1);
        check("t1_no_early_done", done, 0);
        result_val = 1'b1;
        result_rdy = 1'b1;
        tick();
        result_val = 1'b0;
        result_rdy = 1'b0;
        check("t1_done_after_result", done, 1);
        wait_done();

        // 2: beat_nb=3, pass_nb=2, res_nb=0, image_rdy toggling
        cfg_write(5'd0, 32'h0000_0003);
        push_run(6, 3);
        push_done(1'b0);
        pulse_start();
        drive_beats(6, 1'b1);
        wait_done();

        // 3: pass_nb=0 completes straight away
        cfg_write(5'd1, 32'd0);
        push_done(1'b0);
        strm.image_rdy = 1'b1;
        pulse_start();
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        check("t3_src_rdy", strm.src_rdy, 0);
        tick();
        check("t3_src_rdy_after", strm.src_rdy, 0);
        check("t3_done_cleared", done, 0);
        strm.image_rdy = 1'b0;
        wait_done();

        // 4: config rewritten mid-run only affects the next run
        cfg_write(5'd0, 32'h0000_0004);
        cfg_write(5'd1, 32'd2);
        push_run(8, 4);
        push_done(1'b0);
        pulse_start();
        drive_beats(2, 1'b0);
        cfg_write(5'd0, 32'h0000_0008);
        cfg_write(5'd1, 32'd1);
        drive_beats(6, 1'b0);
        wait_done();
        push_run(8, 8);
        push_done(1'b0);
        pulse_start();
        drive_beats(8, 1'b0);
        wait_done();

        // 5: reset after 5 beats aborts without done
        cfg_write(5'd0, 32'h0000_0004);
        cfg_write(5'd1, 32'd2);
        push_run(5, 4);
        pulse_start();
        drive_beats(5, 1'b0);
        check("t5_ker_before_rst", ker_addr, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_ker_addr", ker_addr, 0);
        check("t5_done", done, 0);
        tick();
        check("t5_done_later", done, 0);
        cfg_write(5'd0, 32'h0000_0004);
        cfg_write(5'd1, 32'd2);
        push_run(8, 4);
        push_done(1'b0);
        pulse_start();
        drive_beats(8, 1'b0);
        wait_done();

`ifdef SCHED_TIMEOUT_EN
        // 6: watchdog with no results
        begin
            int cnt;
            cnt = 0;
            cfg_write(5'd0, 32'h0001_0001);
            cfg_write(5'd1, 32'd1);
            push_run(1, 1);
            push_done(1'b1);
            pulse_start();
            drive_beats(1, 1'b0);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) break;
                cnt++;
            end
            check("t6_drain_cycles", cnt, 15);
            tick();
            tick();
            check("t6_error_held", error, 1);
            cfg_write(5'd1, 32'd0);
            push_done(1'b0);
            pulse_start();
            check("t6_error_cleared", error, 0);
            wait_done();
        end
`endif

        strm.src_val = 1'b0;
        repeat (3) tick();
        check("exp_q_empty", exp_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
